// File: rtl/sc_obstacle_spawn_pkg.sv
// Shared types and constants for the obstacle spawner.
// Score counter is built only when SC_OBSTACLE_SPAWN_SCORE_EN is defined.
package sc_obstacle_spawn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_FREEZE = 2'b10
  } state_t;

  localparam int LANES   = 4;
  localparam int SCORE_W = 8;

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] sel);
    lane_onehot = '0;
    lane_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/sc_obstacle_spawn_rowgen.sv
// Builds the next top row and next gap count from the random word.
// At most one lane is ever set; rnd[3:2]==0 means no spawn.
module sc_obstacle_spawn_rowgen
  import sc_obstacle_spawn_pkg::*;
#(
  parameter int OBS_MIN_GAP = 2,
  parameter int GW = 2
) (
  input  logic [3:0]       i_rnd,
  input  logic [GW-1:0]    i_gap,
  output logic [LANES-1:0] o_row,
  output logic [GW-1:0]    o_gap
);

  always_comb begin
    o_row = '0;
    o_gap = i_gap;
    if (i_gap < GW'(OBS_MIN_GAP)) begin
      o_gap = i_gap + GW'(1);
    end else if (i_rnd[3:2] != 2'b00) begin
      o_row = lane_onehot(i_rnd[1:0]);
      o_gap = '0;
    end else begin
      o_gap = GW'(OBS_MIN_GAP);
    end
  end

endmodule

// File: rtl/sc_obstacle_spawn.sv
// Scrolling obstacle field with IDLE/RUN/FREEZE control.
// Define SC_OBSTACLE_SPAWN_SCORE_EN to enable the passed-obstacle score.
module sc_obstacle_spawn
  import sc_obstacle_spawn_pkg::*;
#(
  parameter int OBS_ROWS    = 8,
  parameter int OBS_MIN_GAP = 2
) (
  input  logic                  SC_OBSTACLE_SPAWN_CLOCK_50,
  input  logic                  SC_OBSTACLE_SPAWN_RESET_InLow,
  input  logic [3:0]            SC_OBSTACLE_SPAWN_rnd_InBUS,
  input  logic                  SC_OBSTACLE_SPAWN_tick_InLow,
  input  logic                  SC_OBSTACLE_SPAWN_start_InLow,
  input  logic                  SC_OBSTACLE_SPAWN_crash_InLow,
  output logic [4*OBS_ROWS-1:0] SC_OBSTACLE_SPAWN_field_OutBUS,
  output logic                  SC_OBSTACLE_SPAWN_passed_OutLow,
  output logic                  SC_OBSTACLE_SPAWN_run_OutLow,
  output logic [SCORE_W-1:0]    SC_OBSTACLE_SPAWN_score_OutBUS
);

  localparam int GW0 = $clog2(OBS_MIN_GAP + 1);
  localparam int GW  = (GW0 < 1) ? 1 : GW0;
  localparam int FW  = 4 * OBS_ROWS;

  state_t          r_state;
  logic [FW-1:0]   r_field;
  logic [GW-1:0]   r_gap;
  logic            r_passed;
  logic            r_run;
  logic [LANES-1:0] w_row;
  logic [GW-1:0]   w_gap;
  logic            w_tick;
  logic            w_start;
  logic            w_crash;
  logic            w_bottom;

  assign w_tick   = ~SC_OBSTACLE_SPAWN_tick_InLow;
  assign w_start  = ~SC_OBSTACLE_SPAWN_start_InLow;
  assign w_crash  = ~SC_OBSTACLE_SPAWN_crash_InLow;
  assign w_bottom = |r_field[FW-1 -: 4];

  sc_obstacle_spawn_rowgen #(
    .OBS_MIN_GAP(OBS_MIN_GAP),
    .GW(GW)
  ) u_rowgen (
    .i_rnd(SC_OBSTACLE_SPAWN_rnd_InBUS),
    .i_gap(r_gap),
    .o_row(w_row),
    .o_gap(w_gap)
  );

  always_ff @(posedge SC_OBSTACLE_SPAWN_CLOCK_50 or
              negedge SC_OBSTACLE_SPAWN_RESET_InLow) begin
    if (!SC_OBSTACLE_SPAWN_RESET_InLow) begin
      r_state  <= ST_IDLE;
      r_field  <= '0;
      r_gap    <= '0;
      r_passed <= 1'b1;
      r_run    <= 1'b1;
    end else begin
      r_passed <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          r_field <= '0;
          if (w_start) begin
            r_state <= ST_RUN;
            r_gap   <= '0;
            r_run   <= 1'b0;
          end
        end
        ST_RUN: begin
          // crash wins over a same-cycle tick
          if (w_crash) begin
            r_state <= ST_FREEZE;
            r_run   <= 1'b1;
          end else if (w_tick) begin
            r_field  <= {r_field[FW-5:0], w_row};
            r_gap    <= w_gap;
            r_passed <= ~w_bottom;
          end
        end
        ST_FREEZE: begin
          if (w_start) begin
            r_state <= ST_RUN;
            r_field <= '0;
            r_gap   <= '0;
            r_run   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_field <= '0;
          r_run   <= 1'b1;
        end
      endcase
    end
  end

`ifdef SC_OBSTACLE_SPAWN_SCORE_EN
  logic [SCORE_W-1:0] r_score;

  always_ff @(posedge SC_OBSTACLE_SPAWN_CLOCK_50 or
              negedge SC_OBSTACLE_SPAWN_RESET_InLow) begin
    if (!SC_OBSTACLE_SPAWN_RESET_InLow) begin
      r_score <= '0;
    end else if (r_state != ST_RUN) begin
      if (w_start) r_score <= '0;
    end else if (!w_crash && w_tick && w_bottom) begin
      if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
    end
  end

  assign SC_OBSTACLE_SPAWN_score_OutBUS = r_score;
`else
  assign SC_OBSTACLE_SPAWN_score_OutBUS = '0;
`endif

  assign SC_OBSTACLE_SPAWN_field_OutBUS  = r_field;
  assign SC_OBSTACLE_SPAWN_passed_OutLow = r_passed;
  assign SC_OBSTACLE_SPAWN_run_OutLow    = r_run;

endmodule

// File: tb/tb_sc_obstacle_spawn.sv
// Directed bench for sc_obstacle_spawn (OBS_ROWS=8, OBS_MIN_GAP=2).
// Score expectations follow SC_OBSTACLE_SPAWN_SCORE_EN.
module tb_sc_obstacle_spawn;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rnd;
  logic        tick_n;
  logic        start_n;
  logic        crash_n;
  logic [31:0] field;
  logic        passed_n;
  logic        run_n;
  logic [7:0]  score;

  int n_chk;
  int n_pass;
  int n_seen;
  int n_ticks;

  sc_obstacle_spawn #(.OBS_ROWS(8), .OBS_MIN_GAP(2)) dut (
    .SC_OBSTACLE_SPAWN_CLOCK_50(clk),
    .SC_OBSTACLE_SPAWN_RESET_InLow(rst_n),
    .SC_OBSTACLE_SPAWN_rnd_InBUS(rnd),
    .SC_OBSTACLE_SPAWN_tick_InLow(tick_n),
    .SC_OBSTACLE_SPAWN_start_InLow(start_n),
    .SC_OBSTACLE_SPAWN_crash_InLow(crash_n),
    .SC_OBSTACLE_SPAWN_field_OutBUS(field),
    .SC_OBSTACLE_SPAWN_passed_OutLow(passed_n),
    .SC_OBSTACLE_SPAWN_run_OutLow(run_n),
    .SC_OBSTACLE_SPAWN_score_OutBUS(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SC_OBSTACLE_SPAWN_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // one clock with the given strobes asserted; sample 1ns after the edge
  task automatic step(input logic t, input logic s, input logic c,
                      input logic [3:0] r);
    @(negedge clk);
    rnd = r; tick_n = ~t; start_n = ~s; crash_n = ~c;
    @(posedge clk);
    #1;
    tick_n = 1'b1; start_n = 1'b1; crash_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_seen = 0; n_ticks = 0;
    rst_n = 1'b0; rnd = 4'h0;
    tick_n = 1'b1; start_n = 1'b1; crash_n = 1'b1;
    #22;
    check("rst_field", field, 32'h0);
    check("rst_run", run_n, 1'b1);
    check("rst_passed", passed_n, 1'b1);
    check("rst_score", score, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 0, 0, 4'h6);
    check("idle_tick_ignored", field, 32'h0);
    check("idle_run", run_n, 1'b1);

    step(0, 1, 0, 4'h0);
    check("start_run", run_n, 1'b0);

    step(1, 0, 0, 4'h6);
    check("gap_t1", field, 32'h0);
    step(1, 0, 0, 4'h6);
    check("gap_t2", field, 32'h0);
    step(1, 0, 0, 4'h6);
    check("spawn_t3", field, 32'h4);

    step(1, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    check("refill_gap", field, 32'h400);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 4'h3);
    check("no_spawn_rnd3", field, 32'h0400_0000);
    check("no_pass_yet", passed_n, 1'b1);

    step(0, 0, 0, 4'h4);
    check("hold_no_tick", field, 32'h0400_0000);
    step(0, 1, 0, 4'h4);
    check("start_in_run", field, 32'h0400_0000);
    check("start_in_run_runn", run_n, 1'b0);

    step(1, 0, 0, 4'h4);
    check("gap_saturated", field, 32'h4000_0001);
    check("no_pass_t7", passed_n, 1'b1);

    step(1, 0, 0, 4'h0);
    check("pass_pulse", passed_n, 1'b0);
    check("after_pass_field", field, 32'h10);
    check("score_one", score, SCORE_ON ? 8'd1 : 8'd0);
    step(0, 0, 0, 4'h0);
    check("pass_one_cycle", passed_n, 1'b1);

    step(1, 0, 1, 4'h4);
    check("crash_field", field, 32'h10);
    check("crash_no_pass", passed_n, 1'b1);
    check("crash_run", run_n, 1'b1);
    step(1, 0, 1, 4'h4);
    check("freeze_hold", field, 32'h10);
    check("freeze_score", score, SCORE_ON ? 8'd1 : 8'd0);

    step(0, 1, 0, 4'h0);
    check("restart_field", field, 32'h0);
    check("restart_run", run_n, 1'b0);
    check("restart_score", score, 8'd0);

    while (n_seen < 260 && n_ticks < 2000) begin
      step(1, 0, 0, 4'h4);
      n_ticks++;
      if (passed_n === 1'b0) n_seen++;
    end
    check("pass_count", n_seen, 260);
    check("score_sat", score, SCORE_ON ? 8'd255 : 8'd0);
    check("field_busy", {31'd0, field != 32'h0}, 32'd1);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_field", field, 32'h0);
    check("mid_rst_score", score, 8'd0);
    check("mid_rst_run", run_n, 1'b1);
    check("mid_rst_passed", passed_n, 1'b1);
    #2;
    rst_n = 1'b1;
    step(0, 1, 0, 4'h0);
    check("post_rst_start", run_n, 1'b0);
    step(1, 0, 0, 4'h4);
    check("post_rst_gap", field, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sc_obstacle_spawn.md
SC_OBSTACLE_SPAWN -- requirements
Module: sc_obstacle_spawn

Interface
REQ-001 Parameter OBS_ROWS, default 8, number of road rows held in the obstacle field (row 0 = top).
REQ-002 Parameter OBS_MIN_GAP, default 2, minimum count of empty rows between two spawned obstacles.
REQ-003 Lane count SHALL be fixed at 4, matching the 4-bit random source width.
REQ-004 SC_OBSTACLE_SPAWN_CLOCK_50  in  1  system clock; all state on rising edge.
REQ-005 SC_OBSTACLE_SPAWN_RESET_InLow  in  1  asynchronous, active-low reset.
REQ-006 SC_OBSTACLE_SPAWN_rnd_InBUS  in  4  pseudo-random word from the upstream LFSR stage.
REQ-007 SC_OBSTACLE_SPAWN_tick_InLow  in  1  active-low one-cycle scroll strobe.
REQ-008 SC_OBSTACLE_SPAWN_start_InLow  in  1  active-low start/restart request.
REQ-009 SC_OBSTACLE_SPAWN_crash_InLow  in  1  active-low collision report from the player stage.
REQ-010 SC_OBSTACLE_SPAWN_field_OutBUS  out  4*OBS_ROWS  obstacle field; row r at bits [4r+3:4r], bit n = lane n.
REQ-011 SC_OBSTACLE_SPAWN_passed_OutLow  out  1  active-low one-cycle pulse when an obstacle leaves the bottom row.
REQ-012 SC_OBSTACLE_SPAWN_run_OutLow  out  1  low while in RUN.
REQ-013 SC_OBSTACLE_SPAWN_score_OutBUS  out  8  count of passed obstacles.

Function
REQ-014 FSM states SHALL be IDLE, RUN, FREEZE; reset state IDLE.
REQ-015 IDLE: field held 0; start -> RUN next edge, gap counter cleared to 0, score cleared to 0.
REQ-016 RUN, on tick: row r+1 <= row r for r = 0..OBS_ROWS-2; row 0 <= generated row; old bottom row discarded.
REQ-017 Row generation: gap counter < OBS_MIN_GAP -> row 0 = 4'b0000, gap counter +1.
REQ-018 Row generation: gap counter >= OBS_MIN_GAP and rnd[3:2] != 2'b00 -> row 0 = one-hot of rnd[1:0], gap counter <= 0.
REQ-019 Row generation: gap counter >= OBS_MIN_GAP and rnd[3:2] == 2'b00 -> row 0 = 0, gap counter saturates at OBS_MIN_GAP.
REQ-020 A row SHALL never contain more than one obstacle; rnd = 4'b0000 SHALL be treated as no-spawn.
REQ-021 passed SHALL pulse low for exactly the cycle after a tick in RUN whose discarded bottom row was non-zero.
REQ-022 RUN, no tick: field and gap counter hold.
REQ-023 RUN, crash: -> FREEZE; crash has priority over a same-cycle tick (no shift, no passed pulse).
REQ-024 FREEZE: field, score held; tick and crash ignored; start -> RUN with field cleared, gap counter 0, score 0.
REQ-025 start in RUN SHALL be ignored; tick in IDLE or FREEZE SHALL be ignored.
REQ-026 rnd SHALL be sampled only in the tick cycle; no internal register of rnd.

Reset
REQ-027 Reset assertion SHALL immediately force: state IDLE, field 0, gap counter 0, score 0, passed high, run high.
REQ-028 Reset asserted mid-RUN SHALL discard all in-flight rows with no passed pulse.
REQ-029 Leaving reset SHALL require no extra cycles; first edge after release evaluates normally.

Configuration
REQ-030 Macro SC_OBSTACLE_SPAWN_SCORE_EN defined: score increments by 1 on each passed pulse, saturating at 255.
REQ-031 Macro undefined: score port present, tied to 8'd0, counter logic absent.

Structure
REQ-032 Shared package SHALL hold FSM state encodings (IDLE=2'b00, RUN=2'b01, FREEZE=2'b10), lane count 4, score width 8.
REQ-033 Row generation (REQ-017..020) SHALL live in sub-module sc_obstacle_spawn_rowgen: inputs rnd, gap counter; outputs new row, next gap counter.

Verification
REQ-034 Reset, start, rnd=4'b0110, OBS_MIN_GAP=2, 3 ticks -> row 0 after ticks 1,2 = 4'b0000; after tick 3 = 4'b0100.
REQ-035 After gap satisfied, rnd=4'b0011 for 4 ticks -> four empty rows inserted, gap counter stays 2.
REQ-036 Single obstacle spawned, OBS_ROWS=8 further ticks -> passed low exactly one cycle on 8th; score=1 (macro on).
REQ-037 crash and tick same cycle in RUN -> FREEZE, field unchanged, no passed; then start -> field 0, run low.
REQ-038 Reset asserted mid-RUN between clock edges -> field, score 0 and run high before next edge.
REQ-039 Macro on: 260 passed obstacles -> score 255; macro off: score 0 throughout.
